// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Mini-SRC datapath: fetch, then per-opcode execute.
// state | meaning: RST preload PC, T0-T2 fetch, T3-T7 execute, HALT stopped until clear.
module control_unit #(
  parameter logic [31:0] PC_START = 32'd0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        stop,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        BAout,
  output logic        InPortout,
  output logic        Cout,
  output logic        HIout,
  output logic        LOout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zhighin,
  output logic        Zlowin,
  output logic        HIin,
  output logic        LOin,
  output logic        OutPortin,
  output logic        CONin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  alu_op,
  output logic [31:0] pc_init,
  output logic        pc_load,
  output logic        Run
);

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_e     state_q;
  logic [4:0] op;
  logic       is_alu, is_imm, is_ldi, is_mem, is_md, is_halt;
  state_e     last_st;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign pc_init   = PC_START;

  assign is_alu  = (op >= OP_ADD) && (op <= OP_SHL);
  assign is_imm  = (op >= OP_ADDI) && (op <= OP_ORI);
  assign is_ldi  = (op == OP_LDI);
  assign is_mem  = (op == OP_LD) || (op == OP_ST);
  assign is_md   = (op == OP_MUL) || (op == OP_DIV);
  assign is_halt = (op == OP_HALT);

  always_comb begin
    last_st = ST_T3;
    if (is_alu || is_imm || is_ldi) last_st = ST_T5;
    else if (is_md)                 last_st = ST_T6;
    else if (is_mem)                last_st = ST_T7;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_RST;
    end else begin
      case (state_q)
        ST_RST:  state_q <= ST_T0;
        ST_HALT: state_q <= ST_HALT;
        ST_T0, ST_T1, ST_T2: state_q <= state_e'(state_q + 4'd1);
        default: begin
          // stop only matters on the edge that ends an instruction
          if (state_q == ST_T3 && is_halt) state_q <= ST_HALT;
          else if (state_q == last_st)     state_q <= stop ? ST_HALT : ST_T0;
          else                             state_q <= state_e'(state_q + 4'd1);
        end
      endcase
    end
  end

  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; BAout = 1'b0;
    InPortout = 1'b0; Cout = 1'b0; HIout = 1'b0; LOout = 1'b0;
    PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zhighin = 1'b0; Zlowin = 1'b0; HIin = 1'b0; LOin = 1'b0; OutPortin = 1'b0; CONin = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    alu_op = 5'd0; pc_load = 1'b0; Run = 1'b1;
    case (state_q)
      ST_RST:  begin Run = 1'b0; pc_load = 1'b1; end
      ST_HALT: Run = 1'b0;
      ST_T0:   begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
      ST_T1:   begin Read = 1'b1; MDRin = 1'b1; end
      ST_T2:   begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        if (is_alu || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_ldi || is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_md) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else begin
          case (op)
            OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            default: ;
          endcase
        end
      end
      ST_T4: begin
        if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; alu_op = op;
        end else if (is_imm || is_ldi || is_mem) begin
          Cout = 1'b1; Zlowin = 1'b1;
          case (op)
            OP_ANDI: alu_op = OP_AND;
            OP_ORI:  alu_op = OP_OR;
            default: alu_op = OP_ADD;
          endcase
        end else if (is_md) begin
          Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; Zhighin = 1'b1; alu_op = op;
        end
      end
      ST_T5: begin
        if (is_alu || is_imm || is_ldi) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_mem) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (is_md) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end
      end
      ST_T6: begin
        if (op == OP_LD) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (op == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (is_md) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end
      end
      ST_T7: begin
        if (op == OP_LD) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (op == OP_ST) begin
          Write = 1'b1;
        end
      end
      default: Run = 1'b0;
    endcase
  end

endmodule
